// File: rtl/magic_buttons.sv
// Request-level generator for the magic/NMI controller: merges the debounced MAGIC
// button and decoded PS/2 key events into levels held stable across a frame boundary.
module magic_buttons #(
  parameter int unsigned DEBOUNCE_TICKS = 17500,
  parameter int unsigned LONG_FRAMES    = 50,
  parameter logic [7:0]  KEY_MAGIC      = 8'h78,
  parameter logic [7:0]  KEY_PAUSE      = 8'h7E,
  parameter logic [7:0]  KEY_FF         = 8'h07
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       ck35,
  input  logic       n_int,
  input  logic       n_int_next,
  input  logic       btn_n,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       key_release,
  input  logic       key_extended,
  output logic       magic_button,
  output logic       pause_button,
  output logic       fastforward_button
);

  localparam int unsigned     DB_W    = (DEBOUNCE_TICKS > 2) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [5:0]      LONG_N  = 6'(LONG_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LONG
  } btn_state_t;

  btn_state_t      state;
  logic            sync1;
  logic            btn_s;
  logic            acc_lvl;
  logic [DB_W-1:0] db_cnt;
  logic [5:0]      frame_cnt;
  logic            key_ff;

  logic       fb;
  logic       db_fire;
  logic       acc_press;
  logic       acc_release;
  logic [5:0] frame_inc;
  logic       long_enter;
  logic       btn_ff_nxt;
  logic       key_make;
  logic       key_break;
  logic       set_magic;
  logic       set_pause;
  logic       key_ff_nxt;
  logic       ff_req_nxt;

  always_comb begin
    fb          = n_int & ~n_int_next;
    db_fire     = ck35 && (btn_s != acc_lvl) && (db_cnt == DB_LAST);
    acc_press   = db_fire & btn_s;
    acc_release = db_fire & ~btn_s;
    frame_inc   = (frame_cnt == 6'd63) ? frame_cnt : frame_cnt + 6'd1;
    // A release in the same cycle as the final boundary still counts as a short press.
    long_enter  = (state == HELD) && !acc_release && fb && (frame_inc >= LONG_N);
    btn_ff_nxt  = long_enter || ((state == LONG) && !acc_release);
    key_make    = key_valid && !key_extended && !key_release;
    key_break   = key_valid && !key_extended && key_release;
    set_magic   = (key_make && (key_code == KEY_MAGIC)) || ((state == HELD) && acc_release);
    set_pause   = key_make && (key_code == KEY_PAUSE);
    key_ff_nxt  = key_ff;
    if (key_make && (key_code == KEY_FF)) begin
      key_ff_nxt = 1'b1;
    end else if (key_break && (key_code == KEY_FF)) begin
      key_ff_nxt = 1'b0;
    end
    ff_req_nxt  = btn_ff_nxt | key_ff_nxt;
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      sync1   <= 1'b0;
      btn_s   <= 1'b0;
      acc_lvl <= 1'b0;
      db_cnt  <= '0;
    end else begin
      sync1 <= ~btn_n;
      btn_s <= sync1;
      if (btn_s == acc_lvl) begin
        db_cnt <= '0;
      end else if (ck35) begin
        if (db_cnt == DB_LAST) begin
          acc_lvl <= btn_s;
          db_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      state              <= IDLE;
      frame_cnt          <= '0;
      key_ff             <= 1'b0;
      magic_button       <= 1'b0;
      pause_button       <= 1'b0;
      fastforward_button <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_press) begin
            state     <= HELD;
            frame_cnt <= '0;
          end
        end
        HELD: begin
          if (acc_release) begin
            state <= IDLE;
          end else if (fb) begin
            frame_cnt <= frame_inc;
            if (long_enter) state <= LONG;
          end
        end
        LONG: begin
          if (acc_release) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      key_ff <= key_ff_nxt;

      // Output register doubles as the pending flag; a fresh set beats the boundary clear.
      if (set_magic) begin
        magic_button <= 1'b1;
      end else if (fb && magic_button) begin
        magic_button <= 1'b0;
      end

      if (set_pause) begin
        pause_button <= 1'b1;
      end else if (fb && pause_button) begin
        pause_button <= 1'b0;
      end

      if (ff_req_nxt) begin
        fastforward_button <= 1'b1;
      end else if (fb) begin
        fastforward_button <= 1'b0;
      end
    end
  end

endmodule
